bn_frame_loader: RTL
====================

Name: bn_frame_loader

Overview:
- Upstream feeder for the recursive bitonic sorting network, which is combinational and takes 2**LP elements of dw bits each.
- Accepts one element per cycle on a valid/ready stream and packs elements into a frame register of 2**LP slots.
- Pads short frames, which are terminated by s_last, with a sentinel value.
- Presents the full frame in parallel, with valid/ready, directly to the sorter input d_in.

Parameters:
- LP, 3, log2 of frame size; PN = 2**LP slots, LP >= 1.
- dw, 8, element width in bits.
- PAD_HI, 1, pad value select: 1 pads with all-ones (sorts last ascending); 0 pads with all-zeros.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input element valid.
- s_ready  output  1  loader can accept an element.
- s_data  input  dw  input element.
- s_last  input  1  final element of the current frame; qualified by s_valid.
- f_valid  output  1  frame valid.
- f_ready  input  1  downstream accepts frame.
- f_data  output  [2**LP-1:0][dw-1:0]  packed frame; slot 0 holds the first accepted element. Connects straight to the sorter d_in.
- f_count  output  LP+1  number of real (non-pad) elements in the frame, 1..PN.

Behaviour:
- Definitions:
  - Accept = s_valid && s_ready at a rising clk.
  - Frame handshake = f_valid && f_ready at a rising clk.
  - PAD = {dw{PAD_HI}}.
- States: FILL and HOLD. State is registered; all outputs come from registers or state only, with no combinational path from s_* to f_*.
- Reset (rst=1 at clk edge):
  - state=FILL, idx=0, every slot=PAD.
  - f_valid=0, f_count=0, s_ready=1 (as soon as rst deasserts).
  - Overrides every other event in the same cycle.
  - A partial frame in progress is discarded; a frame held in HOLD is dropped.
- FILL:
  - s_ready=1, f_valid=0.
  - On accept: slot[idx] <= s_data.
  - If idx==PN-1 or s_last: f_count <= idx+1, state <= HOLD, idx <= 0.
  - Otherwise idx <= idx+1.
  - No accept: nothing changes; gaps in s_valid are allowed anywhere.
- HOLD:
  - s_ready=0, f_valid=1.
  - f_data and f_count are held stable until the frame handshake.
  - On frame handshake: every slot <= PAD, f_count <= 0, state <= FILL.
  - Slots are re-padded on leaving HOLD, so unwritten slots of the next frame already read PAD. No explicit pad pass is needed.
- Latency and throughput:
  - f_valid rises on the cycle after the accept that closes the frame.
  - Minimum 1 bubble cycle per frame: s_ready is low in HOLD, including the handshake cycle.
  - Sustained throughput with f_ready=1 is PN elements per PN+1 cycles.
- Boundary cases:
  - s_last on the PN-th element closes the frame exactly once (f_count=PN).
  - s_last on the 1st element gives f_count=1 and slots 1..PN-1 = PAD.
  - s_last while s_valid=0 is ignored.
  - Empty frames are impossible.
  - f_ready asserted in FILL is ignored.
- Width rules:
  - idx is LP bits and never wraps past PN-1.
  - f_count is LP+1 bits so that it can represent PN.

Test Plan:
- Full frame (LP=3, dw=8, PAD_HI=1): stream 8,7,6,5,4,3,2,1 with s_valid=1 and f_ready=1 -> f_valid=1 on the cycle after the 8th accept; slot0=8, slot7=1; f_count=8; s_ready=0 that cycle.
- Short frame: stream 0x10,0x20,0x30 with s_last on 0x30 -> slots 0..2 = 0x10,0x20,0x30; slots 3..7 = 0xFF; f_count=3. Repeat with PAD_HI=0 -> slots 3..7 = 0x00.
- Backpressure: hold f_ready=0 for 5 cycles after f_valid, with s_valid=1 and s_data=0x55 -> f_data and f_count unchanged, s_ready=0, 0x55 not accepted. Then f_ready=1 for one cycle -> next cycle f_valid=0, s_ready=1, and 0x55 lands in slot 0.
- Back-to-back: 16 continuous elements 0..15 with f_ready=1 -> two frames, {0..7} then {8..15}, exactly one bubble cycle between them; the 16th element is accepted at cycle 17 and the second f_valid appears at cycle 18.
- Reset mid-frame: after 4 accepts, pulse rst for 1 cycle -> f_valid=0, f_count=0, all slots=0xFF. The next 8 elements 0xA0..0xA7 form a clean frame with slot0=0xA0 and f_count=8.
- Single element with gaps: s_valid toggles 1,0,0,1 with s_last on the 2nd accepted element 0x42 -> f_count=2, slot1=0x42, slots 2..7 = 0xFF.

Source files
------------

// File: rtl/bn_frame_loader.sv
// rtl/bn_frame_loader.sv - packs a valid/ready element stream into padded parallel frames for the bitonic sorter
module bn_frame_loader #(
    parameter int LP     = 3,
    parameter int dw     = 8,
    parameter bit PAD_HI = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [dw-1:0]              s_data,
    input  logic                       s_last,
    output logic                       f_valid,
    input  logic                       f_ready,
    output logic [2**LP-1:0][dw-1:0]   f_data,
    output logic [LP:0]                f_count
);

    localparam int              PN       = 2 ** LP;
    localparam logic [dw-1:0]   PAD      = {dw{PAD_HI}};
    localparam logic [LP-1:0]   IDX_LAST = LP'(PN - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]             state;
    logic [LP-1:0]          idx;
    logic [PN-1:0][dw-1:0]  slots;
    logic [LP:0]            count_q;

    logic accept;
    logic close;
    logic handshake;

    // Handshake outputs decode state only, so nothing on s_* reaches f_* combinationally.
    assign s_ready   = (state == ST_FILL);
    assign f_valid   = (state == ST_HOLD);
    assign accept    = s_valid && s_ready;
    assign close     = accept && (s_last || (idx == IDX_LAST));
    assign handshake = f_valid && f_ready;

    assign f_data  = slots;
    assign f_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FILL;
            idx     <= '0;
            slots   <= {PN{PAD}};
            count_q <= '0;
        end else begin
            if (accept) begin
                slots[idx] <= s_data;
                if (close) begin
                    count_q <= {1'b0, idx} + (LP+1)'(1);
                    state   <= ST_HOLD;
                    idx     <= '0;
                end else begin
                    idx <= idx + LP'(1);
                end
            end
            // Re-padding on release means the next short frame needs no explicit pad pass.
            if (handshake) begin
                slots   <= {PN{PAD}};
                count_q <= '0;
                state   <= ST_FILL;
            end
        end
    end

endmodule
